// File: rtl/mem_access_unit.sv
// Load/store sequencer between the execute stage and the data RAM: one
// registered RAM access per request, with alignment trapping and load extension.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_write_data,
    output logic [3:0]        ram_byte_enable,
    output logic              ram_write_enable,
    input  logic [31:0]       ram_dout,
    output logic [31:0]       load_data,
    output logic              busy,
    output logic              done,
    output logic              fault
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        accept_s;
    logic        req_fault_s;
    logic        lane_active_s;
    logic [1:0]  addr_lo_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic        read_r;
    logic        fault_req_r;

    function automatic logic is_malformed(input logic rd, input logic wr,
                                          input logic [1:0] sz, input logic [1:0] lo);
        logic bad;
        case (sz)
            2'b00:   bad = 1'b0;
            2'b01:   bad = lo[0];
            2'b10:   bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad | (rd & wr);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] m;
        case (sz)
            2'b00:   m = 4'b0001 << lo;
            2'b01:   m = lo[1] ? 4'b1100 : 4'b0011;
            2'b10:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                            input logic [1:0] lo, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Next-state and request-acceptance decode
    always_comb begin
        state_next_s  = state_r;
        accept_s      = 1'b0;
        req_fault_s   = is_malformed(mem_read, mem_write, size, addr[1:0]);
        lane_active_s = (mem_read | mem_write) & ~req_fault_s;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next_s = ST_ACCESS;
                    accept_s     = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_next_s = ST_DONE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Request latch, RAM drive and completion; the async clear drops write_enable at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_r        <= 2'b00;
            size_r           <= 2'b00;
            unsigned_r       <= 1'b0;
            read_r           <= 1'b0;
            fault_req_r      <= 1'b0;
            ram_address      <= {ADDR_W{1'b0}};
            ram_write_data   <= 32'h0000_0000;
            ram_byte_enable  <= 4'b0000;
            ram_write_enable <= 1'b0;
            load_data        <= 32'h0000_0000;
            busy             <= 1'b0;
            done             <= 1'b0;
            fault            <= 1'b0;
        end else if (accept_s) begin
            addr_lo_r        <= addr[1:0];
            size_r           <= size;
            unsigned_r       <= unsigned_ld;
            read_r           <= mem_read;
            fault_req_r      <= req_fault_s;
            ram_address      <= addr;
            ram_write_data   <= lane_replicate(size, store_data);
            ram_byte_enable  <= lane_active_s ? lane_mask(size, addr[1:0]) : 4'b0000;
            ram_write_enable <= mem_write & ~req_fault_s;
            busy             <= 1'b1;
            done             <= 1'b0;
            fault            <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            ram_byte_enable  <= 4'b0000;
            ram_write_enable <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b1;
            fault            <= fault_req_r;
            if (read_r && !fault_req_r) begin
                load_data <= extract(ram_dout, size_r, addr_lo_r, unsigned_r);
            end
        end else begin
            ram_byte_enable  <= 4'b0000;
            ram_write_enable <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            fault            <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: behavioural RAM plus request-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_access_unit;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, mem_read, mem_write, unsigned_ld;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       store_data;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_write_data;
    logic [3:0]        ram_byte_enable;
    logic              ram_write_enable;
    logic [31:0]       ram_dout;
    logic [31:0]       load_data;
    logic              busy, done, fault;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_read(mem_read),
        .mem_write(mem_write), .size(size), .unsigned_ld(unsigned_ld),
        .addr(addr), .store_data(store_data), .ram_address(ram_address),
        .ram_write_data(ram_write_data), .ram_byte_enable(ram_byte_enable),
        .ram_write_enable(ram_write_enable), .ram_dout(ram_dout),
        .load_data(load_data), .busy(busy), .done(done), .fault(fault)
    );

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Environment RAM: combinational read, byte-enabled synchronous write
    logic [31:0] ram [0:1023];
    logic        ram_init;
    assign ram_dout = ram[ram_address[11:2]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
        end else if (ram_write_enable) begin
            for (int k = 0; k < 4; k++)
                if (ram_byte_enable[k]) ram[ram_address[11:2]][8*k +: 8] <= ram_write_data[8*k +: 8];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:1023];
    int          vectors = 0, miscompares = 0, done_cnt = 0, we_cnt = 0;
    bit          m_access;
    bit          r_rd, r_wr, r_fault, r_uns;
    logic [1:0]  r_sz;
    logic [31:0] r_addr, r_data;
    bit          e_busy, e_done, e_fault, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata, e_load;

    function automatic bit model_bad(input bit rd, input bit wr, input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (rd && wr);
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 4'(1 << (a % 4));
        else if (sz == 2'd1) return (a % 4 >= 2) ? 4'hC : 4'h3;
        else if (sz == 2'd2) return 4'hF;
        else return 4'h0;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        else if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        else return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [31:0] a, input bit uns);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        if (sz == 2'd0) begin
            v = v & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        if (done === 1'b1) done_cnt++;
        if (ram_write_enable === 1'b1) we_cnt++;
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("we", 32'(ram_write_enable), 32'(e_we));
        chk("be", 32'(ram_byte_enable), 32'(e_be));
        chk("load_data", load_data, e_load);
        if (e_done) chk("fault", 32'(fault), 32'(e_fault));
        if (e_busy) begin
            chk("ram_address", ram_address, e_addr);
            chk("ram_write_data", ram_write_data, e_wdata);
        end
    endtask

    task automatic clear_model();
        m_access = 1'b0;
        {e_busy, e_done, e_fault, e_we} = 4'b0000;
        e_be = 4'h0; e_addr = 32'h0; e_wdata = 32'h0; e_load = 32'h0;
    endtask

    // One cycle: check the current cycle, drive new inputs, predict the next cycle
    task automatic step(input logic st, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        logic [3:0]  be;
        @(negedge clk);
        check_all();
        start = st; mem_read = rd; mem_write = wr; size = sz;
        unsigned_ld = uns; addr = a; store_data = d;
        if (m_access) begin
            e_busy = 1'b0; e_done = 1'b1; e_fault = r_fault; e_we = 1'b0; e_be = 4'h0;
            if (r_rd && !r_fault)
                e_load = model_load(ref_mem[r_addr[11:2]], r_sz, r_addr, r_uns);
            if (r_wr && !r_fault) begin
                w  = model_wdata(r_sz, r_data);
                be = model_be(r_sz, r_addr);
                for (int k = 0; k < 4; k++)
                    if (be[k]) ref_mem[r_addr[11:2]][8*k +: 8] = w[8*k +: 8];
            end
            m_access = 1'b0;
        end else if (st) begin
            r_rd = rd; r_wr = wr; r_sz = sz; r_uns = uns; r_addr = a; r_data = d;
            r_fault = model_bad(rd, wr, sz, a);
            e_busy = 1'b1; e_done = 1'b0; e_fault = 1'b0;
            e_we = wr && !r_fault;
            e_be = (!r_fault && (rd || wr)) ? model_be(sz, a) : 4'h0;
            e_addr = a; e_wdata = model_wdata(sz, d);
            m_access = 1'b1;
        end else begin
            e_busy = 1'b0; e_done = 1'b0; e_fault = 1'b0; e_we = 1'b0; e_be = 4'h0;
        end
    endtask

    task automatic idle_step();
        step(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);
    endtask

    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] d);
        step(1'b1, rd, wr, sz, uns, a, d);
        idle_step();
        idle_step();
    endtask

    initial begin
        int w0, d0, bad, r;
        logic [1:0]  sz;
        logic [31:0] a;
        rst_n = 1'b0; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; size = 2'b00;
        unsigned_ld = 1'b0; addr = 32'h0; store_data = 32'h0; ram_init = 1'b1;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        clear_model();
        @(posedge clk);
        @(posedge clk);
        ram_init = 1'b0;
        @(negedge clk);
        check_all();
        chk("reset_ram_address", ram_address, 32'h0);
        chk("reset_wdata", ram_write_data, 32'h0);
        chk("reset_fault", 32'(fault), 32'h0);
        rst_n = 1'b1;

        w0 = we_cnt;
        op(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF);
        chk("sw_mem", ram[64], 32'hDEAD_BEEF);
        chk("sw_we_cycles", 32'(we_cnt - w0), 32'd1);
        op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("lw_deadbeef", load_data, 32'hDEAD_BEEF);
        chk("lw_fault", 32'(fault), 32'h0);

        op(1'b0, 1'b1, 2'd2, 1'b0, 32'h100, 32'h1122_3344);
        op(1'b0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h0000_00AA);
        chk("sb_mem", ram[64], 32'hAA22_3344);
        op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        chk("lw_after_sb", load_data, 32'hAA22_3344);

        op(1'b0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h80FF_7F80);
        op(1'b1, 1'b0, 2'd0, 1'b0, 32'h200, 32'h0);
        chk("lb", load_data, 32'hFFFF_FF80);
        op(1'b1, 1'b0, 2'd0, 1'b1, 32'h200, 32'h0);
        chk("lbu", load_data, 32'h0000_0080);
        op(1'b1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0);
        chk("lh", load_data, 32'hFFFF_80FF);
        op(1'b1, 1'b0, 2'd1, 1'b1, 32'h202, 32'h0);
        chk("lhu", load_data, 32'h0000_80FF);

        w0 = we_cnt;
        op(1'b0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h5555_5555);
        chk("sh_misalign_fault", 32'(fault), 32'h1);
        op(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
        chk("lw_misalign_fault", 32'(fault), 32'h1);
        op(1'b1, 1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
        chk("size3_fault", 32'(fault), 32'h1);
        op(1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'h7777_7777);
        chk("rdwr_fault", 32'(fault), 32'h1);
        chk("fault_no_we", 32'(we_cnt - w0), 32'd0);
        chk("fault_load_kept", load_data, 32'h0000_80FF);
        chk("fault_mem_kept", ram[64], 32'hAA22_3344);

        d0 = done_cnt;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 3; i++) idle_step();
        chk("start_held_dones", 32'(done_cnt - d0), 32'd2);

        step(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_F00D);
        @(posedge clk);
        #1;
        chk("rst_pre_we", 32'(ram_write_enable), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", 32'(ram_write_enable), 32'h0);
        chk("rst_async_busy", 32'(busy), 32'h0);
        chk("rst_async_be", 32'(ram_byte_enable), 32'h0);
        clear_model();
        idle_step();
        chk("rst_ram_address", ram_address, 32'h0);
        rst_n = 1'b1;
        chk("rst_mem_untouched", ram[192], init_word(192));

        for (int i = 0; i < 600; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'd1) a = a & ~32'h1;
                if (sz == 2'd2) a = a & ~32'h3;
            end
            r = $urandom_range(0, 9);
            step(1'($urandom_range(0, 9) < 6), 1'(r < 4 || r == 9), 1'((r >= 4 && r < 8) || r == 9),
                 sz, 1'($urandom), a, $urandom);
        end
        idle_step();
        idle_step();
        idle_step();

        bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) bad++;
        chk("final_mem_words_differing", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the MIPS execute stage and the data RAM. It accepts one memory request per handshake and drives the RAM's address, write data, byte enables and write enable for exactly one access cycle. On loads it captures the RAM's combinational read word, extracts the addressed byte or halfword and extends it. Misaligned or malformed requests are trapped before they reach the RAM.

## Interface
Parameters:
- ADDR_W, 32, width of request and RAM address.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request strobe; sampled only when busy=0.
- mem_read  in  1  request is a load.
- mem_write  in  1  request is a store.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 invalid.
- unsigned_ld  in  1  1 = zero-extend loads (LBU/LHU), 0 = sign-extend.
- addr  in  ADDR_W  byte address.
- store_data  in  32  store operand, right-justified.
- ram_address  out  ADDR_W  to RAM address.
- ram_write_data  out  32  lane-replicated store data.
- ram_byte_enable  out  4  to RAM byte_enable; bit k is bits [8k+7:8k].
- ram_write_enable  out  1  to RAM write_enable.
- ram_dout  in  32  RAM combinational read word.
- load_data  out  32  extended load result.
- busy  out  1  access in progress.
- done  out  1  one-cycle completion pulse.
- fault  out  1  valid with done; request was rejected.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset: IDLE.
- IDLE/DONE with start=1: latch addr, size, unsigned_ld, store_data and request type; go to ACCESS. With start=0: IDLE.
- ACCESS: always goes to DONE after one cycle.
- DONE: lasts one cycle. A new start is accepted from DONE, giving back-to-back throughput of one request per 2 cycles.
- Fault is set when any of these hold:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]≠00;
  - mem_read and mem_write both 1.
- A faulted request still runs ACCESS, but with ram_byte_enable=0 and ram_write_enable=0. RAM contents are untouched and load_data is unchanged.
- Neither mem_read nor mem_write: a no-op. It completes with fault=0, issues no write and leaves load_data unchanged.
- Store lanes (little-endian):
  - byte: enable = 1<<addr[1:0], data = {4{store_data[7:0]}}.
  - half: enable = 0011 if addr[1]=0, else 1100; data = {2{store_data[15:0]}}.
  - word: enable = 1111, data = store_data.
- Load extract:
  - byte: lane addr[1:0], 8-bit field.
  - half: lane addr[1], 16-bit field.
  - word: full word.
  - Byte and half results are sign- or zero-extended to 32 bits per unsigned_ld.
- Outside ACCESS: ram_write_enable=0 and ram_byte_enable=0. ram_address and ram_write_data hold their last latched values.

## Timing
- Reset values: all outputs 0 (ram_address, ram_write_data, ram_byte_enable, ram_write_enable, load_data, busy, done, fault).
- Asserting rst_n=0 mid-ACCESS drops ram_write_enable immediately, without waiting for a clock edge.
- Request cycle (start sampled at edge N):
  - Between edges N and N+1: busy=1, RAM outputs registered and stable.
  - ram_write_enable is high for exactly this single cycle.
- Completion:
  - At edge N+1, load_data captures the extracted ram_dout.
  - done=1, and fault if applicable, hold from edge N+1 to N+2.
  - busy is 0 in DONE.
- Latency: 1 cycle from start to done, identical for loads, stores, faults and no-ops.
- start while busy=1 is ignored; no queueing.
- Inputs need only be valid at the sampling edge. Request fields are don't-care afterwards.

## Test plan
- Store then load: SW addr=0x100, data 0xDEADBEEF → be=1111, we high 1 cycle. Then LW 0x100 → load_data=0xDEADBEEF, done 1 cycle after start, fault=0.
- Byte store: SB addr=0x103, data 0x000000AA over word 0x11223344 → be=1000, write_data=0xAAAAAAAA. Then LW 0x100 → 0xAA223344.
- Extension: word 0x80FF7F80 at 0x200:
  - LB 0x200 → 0xFFFFFF80; LBU 0x200 → 0x00000080.
  - LH 0x202 → 0xFFFF80FF; LHU 0x202 → 0x000080FF.
- Faults: SH 0x101, LW 0x102, size=11, and read+write together → each gives done=1, fault=1, we never high, RAM and load_data unchanged.
- Handshake: start held high for 4 cycles → 2 requests accepted (IDLE, then DONE). A start pulse while busy=1 produces no extra done.
- Reset: rst_n low during ACCESS of an SW → we falls without a clock edge, all outputs 0, FSM IDLE, target word unchanged or fully written (never partial-lane corruption beyond be).
